ball_ctrl: RTL and testbench
============================

BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 Parameter SCREEN_W, default 640: visible width in pixels.
REQ-002 Parameter SCREEN_H, default 480: visible height in pixels.
REQ-003 Parameter BALL_SIZE, default 10: ball edge length; HALF = BALL_SIZE/2 (5).
REQ-004 Parameter SPEED, default 2: pixels moved per axis per frame.
REQ-005 Parameter PADDLE_H, default 40: paddle height; PADDLE_LX, default 16: left paddle face x; PADDLE_RX, default 624: right paddle face x.
REQ-006 Parameter SERVE_FRAMES, default 60: frames between serve request and motion.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  synchronous, active-low reset.
REQ-009 frame_tick  input  1  one-cycle pulse per frame (start of vertical blank).
REQ-010 serve  input  1  serve request, level-sampled.
REQ-011 pl_y, pr_y  input  10 each  left/right paddle centre y.
REQ-012 ball_x, ball_y  output  10 each  registered ball centre; drives the sprite's sx/sy.
REQ-013 playing  output  1  high while in PLAY.
REQ-014 score_l, score_r  output  1 each  one-cycle pulse: left/right player scored.

Function
REQ-015 FSM states: IDLE, DELAY, PLAY, SCORED; all outputs registered; effect of inputs sampled at edge N is visible after edge N.
REQ-016 IDLE: ball held at (SCREEN_W/2, SCREEN_H/2); serve=1 -> DELAY with frame counter cleared; frame_tick in the same cycle is not counted.
REQ-017 DELAY: each frame_tick increments the counter; the tick on which the counter equals SERVE_FRAMES-1 moves to PLAY with no ball motion; counter width is clog2(SERVE_FRAMES)+1.
REQ-018 serve is ignored in DELAY, PLAY and SCORED.
REQ-019 PLAY: position updates only on a frame_tick cycle; nx = x +/- SPEED, ny = y +/- SPEED per dx/dy, computed as 11-bit signed values so that no underflow occurs.
REQ-020 Top wall: dy up and ny < HALF -> y = HALF, dy = down; bottom: dy down and ny > SCREEN_H-1-HALF -> y = SCREEN_H-1-HALF, dy = up.
REQ-021 Left paddle: dx left, x > PADDLE_LX+HALF-1, nx <= PADDLE_LX+HALF and |y - pl_y| <= PADDLE_H/2+HALF -> x = PADDLE_LX+HALF, dx = right.
REQ-022 Right paddle: mirror of REQ-021 about PADDLE_RX-HALF using pr_y.
REQ-023 Left miss: dx left and nx < HALF with no paddle hit -> SCORED, score_r=1; right miss: dx right and nx > SCREEN_W-1-HALF -> SCORED, score_l=1.
REQ-024 Wall and paddle/miss on the same tick: both axes resolve independently in that tick.
REQ-025 SCORED: lasts exactly one cycle, then IDLE with the ball re-centred; the score pulse is high only in the cycle after the miss edge.
REQ-026 Serve direction: dx after reset = right; after a point, dx points toward the player who conceded; dy persists across points (down after reset).
REQ-027 The position is not updated outside PLAY; frame_tick is ignored in IDLE and SCORED.

Reset
REQ-028 rst_n=0 at an edge, in any state including mid-DELAY or mid-PLAY: state=IDLE, ball=(320,240) at defaults, dx=right, dy=down, counter=0, playing=0, score_l=score_r=0.
REQ-029 While rst_n=0, frame_tick and serve have no effect; operation resumes at the first edge with rst_n=1.

Verification
REQ-030 Reset, then idle 100 frame_ticks -> ball (320,240), playing=0, no score pulses.
REQ-031 serve pulse, then 60 frame_ticks -> playing=1 after tick 60, ball still (320,240); tick 61 -> (322,242).
REQ-032 PLAY, y=6, dy up, tick -> y=5, dy down; next tick -> y=7.
REQ-033 PLAY, x=22, dx left, y=pl_y=200, tick -> x=21, dx right; next tick -> x=23.
REQ-034 PLAY, x=6, dx left, pl_y=400, y=100, tick -> score_r high exactly one cycle, then IDLE at (320,240); serve plus 61 ticks -> x=318.
REQ-035 rst_n low for one edge mid-PLAY at (150,90) -> (320,240), IDLE, playing=0 next cycle.

Source files
------------

// File: rtl/ball_ctrl.sv
// Pong ball controller: serve delay, frame-stepped motion, wall and paddle bounces, and miss scoring.
// All outputs are registered, so the effect of inputs sampled at one edge appears right after that edge.
module ball_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 10,
    parameter int SPEED        = 2,
    parameter int PADDLE_H     = 40,
    parameter int PADDLE_LX    = 16,
    parameter int PADDLE_RX    = 624,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] pl_y,
    input  logic [9:0] pr_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       playing,
    output logic       score_l,
    output logic       score_r
);

    localparam int HALF  = BALL_SIZE / 2;
    localparam int CNT_W = $clog2(SERVE_FRAMES) + 1;

    localparam logic [9:0]       CENTER_X   = 10'(SCREEN_W / 2);
    localparam logic [9:0]       CENTER_Y   = 10'(SCREEN_H / 2);
    localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(SERVE_FRAMES - 1);

    // Signed 11-bit geometry so a step past zero stays negative instead of wrapping.
    localparam logic signed [10:0] STEP      = 11'(SPEED);
    localparam logic signed [10:0] TOP_LIM   = 11'(HALF);
    localparam logic signed [10:0] BOT_LIM   = 11'(SCREEN_H - 1 - HALF);
    localparam logic signed [10:0] LEFT_LIM  = 11'(HALF);
    localparam logic signed [10:0] RIGHT_LIM = 11'(SCREEN_W - 1 - HALF);
    localparam logic signed [10:0] L_FACE    = 11'(PADDLE_LX + HALF);
    localparam logic signed [10:0] R_FACE    = 11'(PADDLE_RX - HALF);
    localparam logic signed [10:0] REACH     = 11'(PADDLE_H / 2 + HALF);

    typedef enum logic [1:0] {IDLE, DELAY, PLAY, SCORED} state_t;

    state_t            state, state_nx;
    logic [9:0]        x_nx, y_nx;
    logic              dx_left, dx_left_nx;
    logic              dy_up, dy_up_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              playing_nx, score_l_nx, score_r_nx;

    logic signed [10:0] cur_x, cur_y, nx, ny;
    logic signed [10:0] dist_l, dist_r, abs_l, abs_r;
    logic               hit_l, hit_r;

    // Candidate next position and paddle contact tests, judged against the current ball y.
    always_comb begin
        cur_x  = signed'({1'b0, ball_x});
        cur_y  = signed'({1'b0, ball_y});
        nx     = dx_left ? cur_x - STEP : cur_x + STEP;
        ny     = dy_up   ? cur_y - STEP : cur_y + STEP;
        dist_l = cur_y - signed'({1'b0, pl_y});
        dist_r = cur_y - signed'({1'b0, pr_y});
        abs_l  = dist_l[10] ? -dist_l : dist_l;
        abs_r  = dist_r[10] ? -dist_r : dist_r;
        hit_l  = dx_left  && (cur_x >= L_FACE) && (nx <= L_FACE) && (abs_l <= REACH);
        hit_r  = !dx_left && (cur_x <= R_FACE) && (nx >= R_FACE) && (abs_r <= REACH);
    end

    always_comb begin
        state_nx   = state;
        x_nx       = ball_x;
        y_nx       = ball_y;
        dx_left_nx = dx_left;
        dy_up_nx   = dy_up;
        cnt_nx     = cnt;
        score_l_nx = 1'b0;
        score_r_nx = 1'b0;

        case (state)
            IDLE: begin
                x_nx = CENTER_X;
                y_nx = CENTER_Y;
                if (serve) begin
                    state_nx = DELAY;
                    cnt_nx   = '0;
                end
            end
            DELAY: begin
                if (frame_tick) begin
                    if (cnt == LAST_FRAME) begin
                        state_nx = PLAY;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (dy_up && ny < TOP_LIM) begin
                        y_nx     = TOP_LIM[9:0];
                        dy_up_nx = 1'b0;
                    end else if (!dy_up && ny > BOT_LIM) begin
                        y_nx     = BOT_LIM[9:0];
                        dy_up_nx = 1'b1;
                    end else begin
                        y_nx = ny[9:0];
                    end

                    // A miss keeps dx aimed at the conceding player for the next serve.
                    if (hit_l) begin
                        x_nx       = L_FACE[9:0];
                        dx_left_nx = 1'b0;
                    end else if (hit_r) begin
                        x_nx       = R_FACE[9:0];
                        dx_left_nx = 1'b1;
                    end else if (dx_left && nx < LEFT_LIM) begin
                        state_nx   = SCORED;
                        score_r_nx = 1'b1;
                        dx_left_nx = 1'b1;
                    end else if (!dx_left && nx > RIGHT_LIM) begin
                        state_nx   = SCORED;
                        score_l_nx = 1'b1;
                        dx_left_nx = 1'b0;
                    end else begin
                        x_nx = nx[9:0];
                    end
                end
            end
            SCORED: begin
                state_nx = IDLE;
                x_nx     = CENTER_X;
                y_nx     = CENTER_Y;
            end
            default: state_nx = IDLE;
        endcase

        playing_nx = (state_nx == PLAY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ball_x  <= CENTER_X;
            ball_y  <= CENTER_Y;
            dx_left <= 1'b0;
            dy_up   <= 1'b0;
            cnt     <= '0;
            playing <= 1'b0;
            score_l <= 1'b0;
            score_r <= 1'b0;
        end else begin
            state   <= state_nx;
            ball_x  <= x_nx;
            ball_y  <= y_nx;
            dx_left <= dx_left_nx;
            dy_up   <= dy_up_nx;
            cnt     <= cnt_nx;
            playing <= playing_nx;
            score_l <= score_l_nx;
            score_r <= score_r_nx;
        end
    end

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: directed serve/reset scenarios, then randomized play against a
// game-level model that tracks position and direction as plain integers.
module tb_ball_ctrl;

    localparam int W      = 640;
    localparam int H      = 480;
    localparam int HALF   = 5;
    localparam int SPD    = 2;
    localparam int PH     = 40;
    localparam int LX     = 16;
    localparam int RX     = 624;
    localparam int SF     = 60;

    localparam int M_IDLE   = 0;
    localparam int M_DELAY  = 1;
    localparam int M_PLAY   = 2;
    localparam int M_SCORED = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic       serve;
    logic [9:0] pl_y;
    logic [9:0] pr_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       playing;
    logic       score_l;
    logic       score_r;

    int tests    = 0;
    int failures = 0;

    // Reference game state: direction is +1/-1, counter counts completed serve frames.
    int m_mode, mx, my, mdx, mdy, mframes;
    int m_sl, m_sr;
    int n_hits, n_walls, n_pts_l, n_pts_r;

    ball_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .serve      (serve),
        .pl_y       (pl_y),
        .pr_y       (pr_y),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .playing    (playing),
        .score_l    (score_l),
        .score_r    (score_r)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int absval(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One clock edge of game behaviour.
    function automatic void model_step(input bit r, input bit t, input bit s, input int pl, input int pr);
        int nx, ny;
        m_sl = 0;
        m_sr = 0;
        if (!r) begin
            m_mode = M_IDLE; mx = W / 2; my = H / 2; mdx = 1; mdy = 1; mframes = 0;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                mx = W / 2; my = H / 2;
                if (s) begin
                    m_mode  = M_DELAY;
                    mframes = 0;
                end
            end
            M_DELAY: begin
                if (t) begin
                    mframes++;
                    if (mframes == SF) m_mode = M_PLAY;
                end
            end
            M_PLAY: begin
                if (t) begin
                    nx = mx + mdx * SPD;
                    ny = my + mdy * SPD;
                    if (mdx < 0 && mx >= LX + HALF && nx <= LX + HALF && absval(my - pl) <= PH / 2 + HALF) begin
                        mx = LX + HALF; mdx = 1; n_hits++;
                    end else if (mdx > 0 && mx <= RX - HALF && nx >= RX - HALF && absval(my - pr) <= PH / 2 + HALF) begin
                        mx = RX - HALF; mdx = -1; n_hits++;
                    end else if (mdx < 0 && nx < HALF) begin
                        m_mode = M_SCORED; m_sr = 1; n_pts_r++;
                    end else if (mdx > 0 && nx > W - 1 - HALF) begin
                        m_mode = M_SCORED; m_sl = 1; n_pts_l++;
                    end else begin
                        mx = nx;
                    end
                    if (mdy < 0 && ny < HALF) begin
                        my = HALF; mdy = 1; n_walls++;
                    end else if (mdy > 0 && ny > H - 1 - HALF) begin
                        my = H - 1 - HALF; mdy = -1; n_walls++;
                    end else begin
                        my = ny;
                    end
                end
            end
            default: begin
                m_mode = M_IDLE; mx = W / 2; my = H / 2;
            end
        endcase
    endfunction

    // Drive one cycle at the falling edge, advance the model, check just after the rising edge.
    task automatic applyStimulus(input bit r, input bit t, input bit s, input int pl, input int pr);
        @(negedge clk);
        rst_n      = r;
        frame_tick = t;
        serve      = s;
        pl_y       = pl[9:0];
        pr_y       = pr[9:0];
        model_step(r, t, s, pl, pr);
        @(posedge clk);
        #1;
        checkOutput("playing", int'(playing), int'(m_mode == M_PLAY));
        checkOutput("score_l", int'(score_l), m_sl);
        checkOutput("score_r", int'(score_r), m_sr);
        if (m_mode != M_SCORED) begin
            checkOutput("ball_x", int'(ball_x), mx);
            checkOutput("ball_y", int'(ball_y), my);
        end
    endtask

    function automatic int paddle_near(input int y);
        int p;
        if ($urandom_range(0, 3) != 0) p = y + int'($urandom_range(0, 64)) - 32;
        else p = int'($urandom_range(0, 479));
        if (p < 0) p = 0;
        if (p > 1023) p = 1023;
        return p;
    endfunction

    initial begin
        int pl, pr;
        bit r, t, s;
        rst_n = 1'b0; frame_tick = 1'b0; serve = 1'b0; pl_y = 10'd240; pr_y = 10'd240;
        m_mode = M_IDLE; mx = W / 2; my = H / 2; mdx = 1; mdy = 1; mframes = 0;
        m_sl = 0; m_sr = 0;
        n_hits = 0; n_walls = 0; n_pts_l = 0; n_pts_r = 0;

        // Reset while ticks and serves are asserted must not leave IDLE.
        repeat (3) applyStimulus(0, 1, 1, 240, 240);
        checkOutput("reset_x", int'(ball_x), 320);
        checkOutput("reset_y", int'(ball_y), 240);
        checkOutput("reset_playing", int'(playing), 0);

        repeat (100) applyStimulus(1, 1, 0, 240, 240);
        checkOutput("idle_x", int'(ball_x), 320);
        checkOutput("idle_playing", int'(playing), 0);

        // Serve coincides with a tick that must not count; then 60 counted ticks.
        applyStimulus(1, 1, 1, 240, 240);
        for (int i = 1; i <= SF; i++) begin
            applyStimulus(1, 0, 0, 240, 240);
            applyStimulus(1, 1, 0, 240, 240);
            if (i == SF - 1) checkOutput("delay_not_yet", int'(playing), 0);
        end
        checkOutput("serve_playing", int'(playing), 1);
        checkOutput("serve_x_held", int'(ball_x), 320);
        checkOutput("serve_y_held", int'(ball_y), 240);
        applyStimulus(1, 1, 0, 240, 240);
        checkOutput("first_move_x", int'(ball_x), 322);
        checkOutput("first_move_y", int'(ball_y), 242);

        repeat (20) applyStimulus(1, 1, 0, 240, 240);
        applyStimulus(0, 1, 0, 240, 240);
        checkOutput("midplay_reset_x", int'(ball_x), 320);
        checkOutput("midplay_reset_y", int'(ball_y), 240);
        checkOutput("midplay_reset_playing", int'(playing), 0);

        for (int c = 0; c < 24000; c++) begin
            r  = ($urandom_range(0, 4999) != 0);
            t  = $urandom_range(0, 1) != 0;
            s  = $urandom_range(0, 15) == 0;
            pl = paddle_near(my);
            pr = paddle_near(my);
            applyStimulus(r, t, s, pl, pr);
        end

        $display("[TB] coverage: %0d paddle hits, %0d wall bounces, %0d left points, %0d right points",
                 n_hits, n_walls, n_pts_l, n_pts_r);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
